ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//   Drives the CPU's 16x1024 single-port data/program RAM on behalf of two requesters:
//   the instruction-fetch unit (IF, read-only) and the load/store unit (LS, read/write).
//   Serialises requests, generates mutually exclusive RAM read/write enables and returns
//   read data with a valid pulse. Sits between the CPU pipeline and the RAM.
// PARAMETERS
//   ADDR_W      10  RAM address width (1024 words)
//   DATA_W      16  RAM data width
//   STARVE_MAX  2   consecutive LS grants allowed while IF waits before IF is forced next
// PORTS
//   clk           in   1       system clock, all logic on rising edge
//   rst_n         in   1       asynchronous active-low reset
//   if_req        in   1       IF read request; held with if_addr until if_valid
//   if_addr       in   ADDR_W  IF word address
//   if_rdata      out  DATA_W  IF read data, valid when if_valid, held until next IF read
//   if_valid      out  1       one-cycle completion pulse for IF
//   ls_req        in   1       LS request; held with ls_we/ls_addr/ls_wdata until ls_valid
//   ls_we         in   1       1 = write, 0 = read
//   ls_addr       in   ADDR_W  LS word address
//   ls_wdata      in   DATA_W  LS write data
//   ls_rdata      out  DATA_W  LS read data, valid when ls_valid on a read, held otherwise
//   ls_valid      out  1       one-cycle completion pulse for LS (reads and writes)
//   ram_read_en   out  1       RAM read enable (never high with ram_write_en)
//   ram_write_en  out  1       RAM write enable
//   ram_addr      out  ADDR_W  RAM address
//   ram_din       out  DATA_W  RAM write data
//   ram_dout      in   DATA_W  RAM read data; valid the cycle after ram_read_en is sampled
// BEHAVIOUR
//   - Reset (async, immediate): state IDLE; ram_read_en/ram_write_en/if_valid/ls_valid = 0;
//     ram_addr, ram_din, if_rdata, ls_rdata = 0; starvation counter = 0. RAM contents untouched.
//   - All outputs registered. FSM: IDLE -> ISSUE -> (write) DONE | (read) WAIT -> DONE -> IDLE.
//   - IDLE: samples requests. Grant rule: LS if ls_req and (!if_req or cnt < STARVE_MAX),
//     else IF if if_req. Latch winner's addr/we/wdata into ram_addr/ram_din; go ISSUE.
//   - ISSUE (1 cycle): exactly one of ram_write_en (LS write) or ram_read_en (read) is high.
//   - WAIT (1 cycle): enables low; ram_dout valid this cycle, captured into winner's rdata.
//   - DONE (1 cycle): winner's valid = 1; return to IDLE. Requests are not sampled in DONE,
//     so a requester dropping req on the valid cycle never causes a duplicate access.
//   - Latency from req sampled in IDLE (cycle 0): write -> ls_valid in cycle 2; read ->
//     valid + data in cycle 3. Back-to-back throughput: write 1 per 3 cycles, read 1 per 4.
//   - Starvation counter: +1 on each LS grant while if_req high (saturate at STARVE_MAX);
//     cleared on IF grant or when if_req low at grant time.
//   - Simultaneous if_req & ls_req with cnt=0: LS wins; IF granted in next IDLE if cnt hits max.
//   - Req changes outside IDLE are ignored (latched operands used). Req dropped before grant:
//     no access. Addresses wrap naturally at ADDR_W; no range fault.
//   - Reset mid-operation: aborts; no valid pulse emitted; a write in ISSUE may or may not
//     have landed in RAM (RAM is not reset-gated) -- software must retry.
//   - Invariant: ram_read_en & ram_write_en is never 1.
// STRUCTURE
//   - Shared include cpu_mem_defs.vh: ADDR_W/DATA_W defaults, FSM state localparams
//     (IDLE, ISSUE, WAIT, DONE, 2-bit), grant encoding (GNT_IF, GNT_LS).
//   - One sub-module: mem_arb_prio -- grant decision + starvation counter (inputs if_req,
//     ls_req, grant_strobe; outputs gnt_ls, gnt_if). FSM and datapath stay in top.
// TESTING
//   1. Reset: hold rst_n=0 mid-ISSUE -> all enables/valids 0 at once; FSM IDLE after release.
//   2. LS write 0x3FF<=0xBEEF, then LS read 0x3FF -> ram_write_en cycle 1, ls_valid cycle 2;
//      read ls_valid cycle 3 with ls_rdata=0xBEEF.
//   3. IF read addr 0x000 after preload 0x1234 -> if_valid cycle 3, if_rdata=0x1234, ls_valid=0.
//   4. if_req and ls_req held continuously -> grant order LS,LS,IF,LS,LS,IF (STARVE_MAX=2).
//   5. Change ls_addr 0x010->0x020 during ISSUE -> RAM accessed at 0x010 only.
//   6. Random mixed traffic 10k cycles -> scoreboard matches shadow RAM; enables never both 1.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller: default sizes,
// FSM state encoding and the requester grant encoding.
package ram_access_ctrl_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between instruction fetch and load/store, with a
// starvation counter that forces an IF grant after STARVE_MAX consecutive
// LS grants taken while IF was waiting.
module mem_arb_prio
  import ram_access_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic ls_req,
  input  logic grant_strobe,
  output logic gnt_ls,
  output logic gnt_if
);

  localparam int              CNT_W   = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // LS has priority unless IF has already been passed over STARVE_MAX times.
  always_comb begin
    gnt_ls = ls_req && (!if_req || (cnt_q < CNT_MAX));
    gnt_if = if_req && !gnt_ls;
  end

  // Count LS grants that overtook a waiting IF; any other grant clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_strobe && (gnt_ls || gnt_if)) begin
      if (gnt_ls && if_req) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Single-port RAM access controller serving the instruction-fetch (read
// only) and load/store (read/write) requesters. One access at a time;
// every output comes straight from a register.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  gnt_e              gnt_sel_q, gnt_sel_d;
  logic              we_q, we_d;
  logic              ram_read_en_q, ram_read_en_d;
  logic              ram_write_en_q, ram_write_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              ls_valid_q, ls_valid_d;

  logic grant_strobe;
  logic gnt_ls, gnt_if;

  // Requests are only looked at while idle.
  assign grant_strobe = (state_q == ST_IDLE);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .ls_req       (ls_req),
    .grant_strobe (grant_strobe),
    .gnt_ls       (gnt_ls),
    .gnt_if       (gnt_if)
  );

  // Next-state and next-output logic; enables and valids default low so each is a single-cycle pulse.
  always_comb begin
    state_d        = state_q;
    gnt_sel_d      = gnt_sel_q;
    we_d           = we_q;
    ram_read_en_d  = 1'b0;
    ram_write_en_d = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_din_d      = ram_din_q;
    if_rdata_d     = if_rdata_q;
    ls_rdata_d     = ls_rdata_q;
    if_valid_d     = 1'b0;
    ls_valid_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_ls) begin
          gnt_sel_d      = GNT_LS;
          we_d           = ls_we;
          ram_addr_d     = ls_addr;
          ram_din_d      = ls_wdata;
          ram_write_en_d = ls_we;
          ram_read_en_d  = !ls_we;
          state_d        = ST_ISSUE;
        end else if (gnt_if) begin
          gnt_sel_d      = GNT_IF;
          we_d           = 1'b0;
          ram_addr_d     = if_addr;
          ram_read_en_d  = 1'b1;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          ls_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gnt_sel_q == GNT_LS) begin
          ls_rdata_d = ram_dout;
          ls_valid_d = 1'b1;
        end else begin
          if_rdata_d = ram_dout;
          if_valid_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      gnt_sel_q      <= GNT_IF;
      we_q           <= 1'b0;
      ram_read_en_q  <= 1'b0;
      ram_write_en_q <= 1'b0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
      if_rdata_q     <= '0;
      ls_rdata_q     <= '0;
      if_valid_q     <= 1'b0;
      ls_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_sel_q      <= gnt_sel_d;
      we_q           <= we_d;
      ram_read_en_q  <= ram_read_en_d;
      ram_write_en_q <= ram_write_en_d;
      ram_addr_q     <= ram_addr_d;
      ram_din_q      <= ram_din_d;
      if_rdata_q     <= if_rdata_d;
      ls_rdata_q     <= ls_rdata_d;
      if_valid_q     <= if_valid_d;
      ls_valid_q     <= ls_valid_d;
    end
  end

  assign ram_read_en  = ram_read_en_q;
  assign ram_write_en = ram_write_en_q;
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;
  assign if_rdata     = if_rdata_q;
  assign if_valid     = if_valid_q;
  assign ls_rdata     = ls_rdata_q;
  assign ls_valid     = ls_valid_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: a 1024x16 RAM model, a shadow memory and
// a grant/starvation reference model built from the arbitration rules.
module tb_ram_access_ctrl;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int SMAX = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [DW-1:0] ls_rdata;
  logic          ls_valid;
  logic          ram_read_en;
  logic          ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] ram_mem [0:1023];
  logic [DW-1:0] shadow  [0:1023];

  int checks = 0;
  int errors = 0;
  int starve = 0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_ls = '0;

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_valid     (if_valid),
    .ls_req       (ls_req),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_rdata     (ls_rdata),
    .ls_valid     (ls_valid),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Synchronous single-port RAM: read data appears the cycle after read_en.
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_addr] <= ram_din;
    if (ram_read_en)  ram_dout <= ram_mem[ram_addr];
  end

  // The two RAM enables must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(ram_read_en === 1'b1 && ram_write_en === 1'b1)) else begin
        errors++;
        $error("[TB] FAIL enable_excl: observed rd=%0b wr=%0b, expected not both 1", ram_read_en, ram_write_en);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 10'h3FF;
      2:       return AW'($urandom_range(0, 7));
      default: return AW'($urandom_range(0, 1023));
    endcase
  endfunction

  // Presents one request pattern in an idle cycle, predicts the winner and
  // its timing, and checks the whole access. Returns the observed winner.
  task automatic applyStimulus(input bit ireq, input bit lreq, input bit lwe,
                               input logic [AW-1:0] iaddr, input logic [AW-1:0] laddr,
                               input logic [DW-1:0] wdata, input bit perturb, input bit keep,
                               output int winner);
    bit            ls_wins;
    bit            is_wr;
    int            lat;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_rd;
    ls_wins = lreq && (!ireq || starve < SMAX);
    if (ls_wins && ireq) starve = (starve < SMAX) ? starve + 1 : SMAX;
    else                 starve = 0;
    is_wr  = ls_wins && lwe;
    a      = ls_wins ? laddr : iaddr;
    exp_rd = shadow[a];
    if (is_wr) shadow[a] = wdata;
    lat    = is_wr ? 2 : 3;
    winner = -1;

    if_req   = ireq;
    ls_req   = lreq;
    ls_we    = lwe;
    if_addr  = iaddr;
    ls_addr  = laddr;
    ls_wdata = wdata;

    for (int k = 1; k <= lat; k++) begin
      step();
      if (k == 1) begin
        checkOutput("ram_read_en", 32'(ram_read_en), 32'(!is_wr));
        checkOutput("ram_write_en", 32'(ram_write_en), 32'(is_wr));
        checkOutput("ram_addr", 32'(ram_addr), 32'(a));
        if (is_wr) checkOutput("ram_din", 32'(ram_din), 32'(wdata));
        if (perturb) begin
          ls_addr  = ls_addr ^ 10'h030;
          ls_wdata = ~ls_wdata;
        end
      end
      if (k < lat) begin
        checkOutput("early_valid", 32'({if_valid, ls_valid}), 32'(0));
      end else begin
        checkOutput("if_valid", 32'(if_valid), 32'(!ls_wins));
        checkOutput("ls_valid", 32'(ls_valid), 32'(ls_wins));
        if (ls_wins && !is_wr) begin
          checkOutput("ls_rdata", 32'(ls_rdata), 32'(exp_rd));
          last_ls = exp_rd;
          checkOutput("if_rdata_held", 32'(if_rdata), 32'(last_if));
        end else if (!ls_wins) begin
          checkOutput("if_rdata", 32'(if_rdata), 32'(exp_rd));
          last_if = exp_rd;
          checkOutput("ls_rdata_held", 32'(ls_rdata), 32'(last_ls));
        end else begin
          checkOutput("ls_rdata_held_wr", 32'(ls_rdata), 32'(last_ls));
          checkOutput("if_rdata_held_wr", 32'(if_rdata), 32'(last_if));
        end
        winner = (if_valid === 1'b1) ? 0 : (ls_valid === 1'b1) ? 1 : -1;
      end
    end
    if (!keep) begin
      if_req = 1'b0;
      ls_req = 1'b0;
    end
    step();
  endtask

  initial begin
    int w;
    int exp_order [6];
    exp_order = '{1, 1, 0, 1, 1, 0};

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = DW'($urandom);
      shadow[i]  = ram_mem[i];
    end
    ram_mem[0] = 16'h1234;
    shadow[0]  = 16'h1234;

    // Reset state
    repeat (3) step();
    checkOutput("rst_read_en", 32'(ram_read_en), 32'(0));
    checkOutput("rst_write_en", 32'(ram_write_en), 32'(0));
    checkOutput("rst_if_valid", 32'(if_valid), 32'(0));
    checkOutput("rst_ls_valid", 32'(ls_valid), 32'(0));
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'(0));
    checkOutput("rst_ram_din", 32'(ram_din), 32'(0));
    checkOutput("rst_if_rdata", 32'(if_rdata), 32'(0));
    checkOutput("rst_ls_rdata", 32'(ls_rdata), 32'(0));
    rst_n = 1'b1;
    step();

    // LS write then read at the top address
    applyStimulus(0, 1, 1, '0, 10'h3FF, 16'hBEEF, 0, 0, w);
    applyStimulus(0, 1, 0, '0, 10'h3FF, 16'h0000, 0, 0, w);
    checkOutput("ls_read_beef", 32'(ls_rdata), 32'h0000BEEF);

    // IF read of preloaded word 0
    applyStimulus(1, 0, 0, 10'h000, '0, '0, 0, 0, w);
    checkOutput("if_read_1234", 32'(if_rdata), 32'h00001234);

    // Operand change during ISSUE must not redirect the write
    applyStimulus(0, 1, 1, '0, 10'h010, 16'hC0DE, 1, 0, w);
    applyStimulus(0, 1, 0, '0, 10'h010, '0, 0, 0, w);
    applyStimulus(0, 1, 0, '0, 10'h020, '0, 0, 0, w);

    // Both requesters held: starvation limit forces every third grant to IF
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 1, 10'h001, 10'h3F0, DW'(16'h5000 + i), 0, 1, w);
      checkOutput($sformatf("grant_order_%0d", i), 32'(w), 32'(exp_order[i]));
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    step();

    // Reset asserted while a write is in ISSUE
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 10'h155;
    ls_wdata = 16'hA5A5;
    step();
    checkOutput("pre_rst_write_en", 32'(ram_write_en), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_read_en", 32'(ram_read_en), 32'(0));
    checkOutput("midrst_write_en", 32'(ram_write_en), 32'(0));
    checkOutput("midrst_valids", 32'({if_valid, ls_valid}), 32'(0));
    checkOutput("midrst_ram_addr", 32'(ram_addr), 32'(0));
    checkOutput("midrst_ls_rdata", 32'(ls_rdata), 32'(0));
    ls_req = 1'b0;
    repeat (2) begin
      step();
      checkOutput("rst_hold_valids", 32'({if_valid, ls_valid}), 32'(0));
    end
    rst_n   = 1'b1;
    starve  = 0;
    last_if = '0;
    last_ls = '0;
    step();
    applyStimulus(0, 1, 1, '0, 10'h155, 16'h0F0F, 0, 0, w);
    applyStimulus(0, 1, 0, '0, 10'h155, '0, 0, 0, w);

    // Random mixed traffic against the shadow memory
    for (int n = 0; n < 2000; n++) begin
      int            sel;
      int            gap;
      sel = $urandom_range(1, 3);
      applyStimulus(sel[0], sel[1], 1'($urandom_range(0, 1)), rand_addr(), rand_addr(),
                    DW'($urandom), 0, 0, w);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        checkOutput("gap_valids", 32'({if_valid, ls_valid}), 32'(0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
